// File: rtl/seg_disp_ctrl.sv
// seg_disp_ctrl: shares a 6-digit segment display between background source A and priority source B,
// with hex-to-segment encoding, leading-zero blanking, decimal points and digit blink.
module seg_disp_ctrl #(
   parameter int HOLD_CYCLES  = 150_000_000,
   parameter int BLINK_CYCLES = 12_500_000,
   parameter bit RETRIGGER    = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [23:0] a_digits,
   input  logic [5:0]  a_dp,
   input  logic [23:0] b_digits,
   input  logic [5:0]  b_dp,
   input  logic        b_valid,
   output logic        b_ready,
   input  logic        lz_blank,
   input  logic [5:0]  blink_mask,
   output logic        showing_b,
   output logic [7:0]  seg_data_0,
   output logic [7:0]  seg_data_1,
   output logic [7:0]  seg_data_2,
   output logic [7:0]  seg_data_3,
   output logic [7:0]  seg_data_4,
   output logic [7:0]  seg_data_5
);
   localparam int HW = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
   localparam int BW = BLINK_CYCLES > 1 ? $clog2(BLINK_CYCLES) : 1;
   localparam logic [7:0] SEG [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
   typedef enum logic {SHOW_A, SHOW_B} state_t;
   state_t state, state_nxt;
   logic [HW-1:0] hold_cnt, hold_nxt;
   logic [BW-1:0] blink_cnt;
   logic blink_wrap, hidden, accept, all_zero;
   logic [23:0] b_q, src_d;
   logic [5:0] b_dp_q, src_p;
   logic [7:0] seg_q [6];
   logic [7:0] seg_nxt [6];
   assign b_ready = !rst && (state == SHOW_A || RETRIGGER);
   assign accept = b_valid && b_ready;
   assign blink_wrap = blink_cnt == BW'(BLINK_CYCLES - 1);
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= SHOW_A;
         hold_cnt <= '0;
      end else begin
         state <= state_nxt;
         hold_cnt <= hold_nxt;
      end
   end
   // An accept always wins over hold expiry, so a retrigger restarts the full hold.
   always_comb begin
      state_nxt = state;
      hold_nxt = hold_cnt;
      if (accept) begin
         state_nxt = SHOW_B;
         hold_nxt = HW'(HOLD_CYCLES - 1);
      end else if (state == SHOW_B) begin
         state_nxt = hold_cnt == '0 ? SHOW_A : SHOW_B;
         hold_nxt = hold_cnt == '0 ? hold_cnt : hold_cnt - HW'(1);
      end
   end
   always_ff @(posedge clk) begin
      if (accept) begin
         b_q <= b_digits;
         b_dp_q <= b_dp;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         blink_cnt <= '0;
         hidden <= 1'b0;
      end else begin
         blink_cnt <= blink_wrap ? '0 : blink_cnt + BW'(1);
         hidden <= hidden ^ blink_wrap;
      end
   end
   // Walk from the top digit down so all_zero means "this nibble and every higher one is 0".
   always_comb begin
      src_d = state == SHOW_B ? b_q : a_digits;
      src_p = state == SHOW_B ? b_dp_q : a_dp;
      all_zero = 1'b1;
      for (int i = 5; i >= 0; i--) begin
         all_zero = all_zero && src_d[4*i +: 4] == 4'h0;
         seg_nxt[i] = (hidden && blink_mask[i]) || (lz_blank && all_zero && i != 0) ? 8'hff
                      : {~src_p[i], SEG[src_d[4*i +: 4]][6:0]};
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         seg_q <= '{default: 8'hff};
         showing_b <= 1'b0;
      end else begin
         seg_q <= seg_nxt;
         showing_b <= state == SHOW_B;
      end
   end
   assign seg_data_0 = seg_q[0];
   assign seg_data_1 = seg_q[1];
   assign seg_data_2 = seg_q[2];
   assign seg_data_3 = seg_q[3];
   assign seg_data_4 = seg_q[4];
   assign seg_data_5 = seg_q[5];
endmodule

// File: tb/tb_seg_disp_ctrl.sv
// tb_seg_disp_ctrl: directed and random checks of seg_disp_ctrl (RETRIGGER=1 and 0) against a frame/hold model.
module tb_seg_disp_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [23:0] a_digits = '0, b_digits = '0;
   logic [5:0] a_dp = '0, b_dp = '0, blink_mask = '0;
   logic b_valid = 1'b0, lz_blank = 1'b0;
   logic b_ready0, b_ready1, showing0, showing1;
   logic [7:0] s0 [6];
   logic [7:0] s1 [6];
   logic [47:0] disp0, disp1;
   int vectors = 0, miscompares = 0, ticks = 0;
   int rem [2] = '{0, 0};
   logic [23:0] fr [2];
   logic [5:0] fdp [2];
   logic [7:0] tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                            8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
   always #5 clk = ~clk;
   assign disp0 = {s0[5], s0[4], s0[3], s0[2], s0[1], s0[0]};
   assign disp1 = {s1[5], s1[4], s1[3], s1[2], s1[1], s1[0]};
   seg_disp_ctrl #(.HOLD_CYCLES(10), .BLINK_CYCLES(4), .RETRIGGER(1'b1)) dut (
      .clk(clk), .rst(rst), .a_digits(a_digits), .a_dp(a_dp), .b_digits(b_digits), .b_dp(b_dp),
      .b_valid(b_valid), .b_ready(b_ready1), .lz_blank(lz_blank), .blink_mask(blink_mask),
      .showing_b(showing1), .seg_data_0(s1[0]), .seg_data_1(s1[1]), .seg_data_2(s1[2]),
      .seg_data_3(s1[3]), .seg_data_4(s1[4]), .seg_data_5(s1[5]));
   seg_disp_ctrl #(.HOLD_CYCLES(10), .BLINK_CYCLES(4), .RETRIGGER(1'b0)) dut0 (
      .clk(clk), .rst(rst), .a_digits(a_digits), .a_dp(a_dp), .b_digits(b_digits), .b_dp(b_dp),
      .b_valid(b_valid), .b_ready(b_ready0), .lz_blank(lz_blank), .blink_mask(blink_mask),
      .showing_b(showing0), .seg_data_0(s0[0]), .seg_data_1(s0[1]), .seg_data_2(s0[2]),
      .seg_data_3(s0[3]), .seg_data_4(s0[4]), .seg_data_5(s0[5]));
   task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   function automatic logic [47:0] exp_disp(input logic [23:0] d, input logic [5:0] p, input bit hid,
                                            input bit lz, input logic [5:0] mask);
      logic [47:0] r;
      logic [3:0] nib;
      r = '0;
      for (int i = 0; i < 6; i++) begin
         nib = 4'((d >> (4 * i)) & 24'hf);
         if (hid && mask[i]) r[8*i +: 8] = 8'hff;
         else if (lz && i > 0 && (d >> (4 * i)) == 24'd0) r[8*i +: 8] = 8'hff;
         else r[8*i +: 8] = tbl[nib] & (p[i] ? 8'h7f : 8'hff);
      end
      return r;
   endfunction
   // One clock: predict from the pre-edge model state and current inputs, advance the model, then compare.
   task automatic tick();
      logic [47:0] e [2];
      logic sh [2];
      logic rdy;
      bit hid;
      #1;
      hid = ((ticks / 4) % 2) == 1;
      for (int r = 0; r < 2; r++) begin
         rdy = !rst && (rem[r] == 0 || r == 1);
         check(r == 1 ? "b_ready_rt1" : "b_ready_rt0", 48'(r == 1 ? b_ready1 : b_ready0), 48'(rdy));
         e[r] = rst ? '1 : exp_disp(rem[r] > 0 ? fr[r] : a_digits, rem[r] > 0 ? fdp[r] : a_dp,
                                    hid, lz_blank, blink_mask);
         sh[r] = !rst && rem[r] > 0;
         if (rst) rem[r] = 0;
         else if (b_valid && rdy) begin
            rem[r] = 10;
            fr[r] = b_digits;
            fdp[r] = b_dp;
         end else if (rem[r] > 0) rem[r]--;
      end
      ticks = rst ? 0 : ticks + 1;
      @(posedge clk);
      #1;
      check("seg_rt0", disp0, e[0]);
      check("seg_rt1", disp1, e[1]);
      check("showing_rt0", 48'(showing0), 48'(sh[0]));
      check("showing_rt1", 48'(showing1), 48'(sh[1]));
   endtask
   initial begin
      a_digits = 24'h123456;
      repeat (3) tick();
      check("reset_seg", disp1, '1);
      rst = 1'b0;
      tick();
      check("after_reset", disp1, 48'hF9A4B0999282);
      a_digits = 24'h000070;
      lz_blank = 1'b1;
      a_dp = 6'b000010;
      tick();
      check("lz_dp", disp1, 48'hFFFFFFFF78C0);
      a_digits = '0;
      tick();
      check("lz_zero", disp1, 48'hFFFFFFFFFFC0);
      a_digits = 24'h123456;
      a_dp = '0;
      lz_blank = 1'b0;
      b_digits = 24'hABCDEF;
      b_valid = 1'b1;
      tick();
      b_valid = 1'b0;
      tick();
      check("b_frame", disp1, 48'h8883C6A1868E);
      repeat (11) tick();
      b_valid = 1'b1;
      tick();
      b_valid = 1'b0;
      repeat (5) tick();
      b_digits = 24'h135790;
      b_dp = 6'b100001;
      b_valid = 1'b1;
      tick();
      b_valid = 1'b0;
      repeat (12) tick();
      blink_mask = 6'b000001;
      repeat (16) tick();
      blink_mask = '0;
      b_digits = 24'hABCDEF;
      b_valid = 1'b1;
      repeat (4) tick();
      rst = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      tick();
      check("rst_mid_b", 48'(showing1), 48'd0);
      b_valid = 1'b0;
      repeat (12) tick();
      for (int n = 0; n < 400; n++) begin
         a_digits = 24'($urandom) >> (4 * $urandom_range(0, 6));
         a_dp = 6'($urandom);
         b_digits = 24'($urandom) >> (4 * $urandom_range(0, 6));
         b_dp = 6'($urandom);
         b_valid = $urandom_range(0, 7) == 0;
         lz_blank = 1'($urandom);
         blink_mask = 6'($urandom);
         rst = $urandom_range(0, 59) == 0;
         tick();
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
